// File: rtl/blockade_bus_ctrl.sv
// Bus glue between the 8080-mode CPU wrapper and Blockade's ROM, RAMs and I/O ports.
// Also owns the VBLANK interrupt and the coin-triggered NMI pulse.
module blockade_bus_ctrl #(
  parameter logic [7:0] INT_VECTOR = 8'hFF,
  parameter int         NMI_WIDTH  = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] CPU_ADDR,
  input  logic [7:0]  CPU_DOUT,
  output logic [7:0]  CPU_DIN,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  output logic        nINT,
  output logic        nNMI,
  output logic [11:0] ROM_ADDR,
  input  logic [7:0]  ROM_DATA,
  output logic [7:0]  RAM_ADDR,
  input  logic [7:0]  RAM_DATA,
  output logic        RAM_WE,
  output logic [9:0]  VRAM_ADDR,
  input  logic [7:0]  VRAM_DATA,
  output logic        VRAM_WE,
  output logic [7:0]  WDATA,
  input  logic [7:0]  IN1,
  input  logic [7:0]  IN2,
  input  logic [7:0]  IN4,
  output logic [7:0]  OUT1,
  output logic [7:0]  OUT2,
  output logic [7:0]  OUT4,
  output logic        SND_STB,
  input  logic        VBLANK,
  input  logic        COIN
);

  typedef struct packed {
    logic mem_rd;
    logic io_rd;
    logic ack;
    logic mem_wr;
    logic io_wr;
  } bus_req_t;

  typedef enum logic [1:0] {NMI_IDLE, NMI_PULSE, NMI_HOLD} nmi_state_t;

  bus_req_t   req;
  nmi_state_t nmi_state;
  logic [7:0] nmi_cnt;
  logic [7:0] port;
  logic       rom_sel, vram_sel, ram_sel;
  logic       wr_q, vb_q, coin_q, ack_q;
  logic       wr_ev, vb_rise, coin_fall, ack_first;
  logic       int_pend, int_next;

  assign ROM_ADDR  = CPU_ADDR[11:0];
  assign RAM_ADDR  = CPU_ADDR[7:0];
  assign VRAM_ADDR = CPU_ADDR[9:0];
  assign WDATA     = CPU_DOUT;
  assign port      = CPU_ADDR[7:0];

  assign rom_sel  = (CPU_ADDR[15:12] == 4'h0);
  assign vram_sel = (CPU_ADDR[15:10] == 6'b100000);
  assign ram_sel  = (CPU_ADDR[15:8]  == 8'hFF);

  // Only the first low cycle of nWR counts, so long strobes write once.
  assign wr_ev     = ~nWR & wr_q & ~RESET;
  assign vb_rise   = VBLANK & ~vb_q;
  assign coin_fall = ~COIN & coin_q;
  assign ack_first = req.ack & ~ack_q;

  always_comb begin
    req        = '0;
    req.mem_rd = ~nMREQ & ~nRD;
    req.io_rd  = ~nIORQ & ~nRD;
    req.ack    = ~nIORQ & nRD & nWR;
    req.mem_wr = ~nMREQ & wr_ev;
    req.io_wr  = ~nIORQ & wr_ev;
  end

  always_comb begin
    CPU_DIN = 8'hFF;
    if (RESET) begin
      CPU_DIN = 8'hFF;
    end else if (req.mem_rd) begin
      if (rom_sel)       CPU_DIN = ROM_DATA;
      else if (vram_sel) CPU_DIN = VRAM_DATA;
      else if (ram_sel)  CPU_DIN = RAM_DATA;
    end else if (req.io_rd) begin
      case (port)
        8'h01:   CPU_DIN = IN1;
        8'h02:   CPU_DIN = IN2;
        8'h04:   CPU_DIN = IN4;
        default: CPU_DIN = 8'hFF;
      endcase
    end else if (req.ack) begin
      CPU_DIN = INT_VECTOR;
    end
  end

  assign RAM_WE  = req.mem_wr & ram_sel;
  assign VRAM_WE = req.mem_wr & vram_sel;
  assign SND_STB = req.io_wr & (port == 8'h08);

  // A VBLANK edge coinciding with an acknowledge must not be lost.
  always_comb begin
    int_next = int_pend;
    if (vb_rise)        int_next = 1'b1;
    else if (ack_first) int_next = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_q      <= 1'b1;
      vb_q      <= 1'b1;
      coin_q    <= 1'b1;
      ack_q     <= 1'b0;
      int_pend  <= 1'b0;
      nINT      <= 1'b1;
      nNMI      <= 1'b1;
      nmi_state <= NMI_IDLE;
      nmi_cnt   <= 8'd0;
      OUT1      <= 8'h00;
      OUT2      <= 8'h00;
      OUT4      <= 8'h00;
    end else begin
      wr_q     <= nWR;
      vb_q     <= VBLANK;
      coin_q   <= COIN;
      ack_q    <= req.ack;
      int_pend <= int_next;
      nINT     <= ~int_next;
      if (req.io_wr) begin
        case (port)
          8'h01:   OUT1 <= CPU_DOUT;
          8'h02:   OUT2 <= CPU_DOUT;
          8'h04:   OUT4 <= CPU_DOUT;
          default: ;
        endcase
      end
      case (nmi_state)
        NMI_IDLE: if (coin_fall) begin
          nmi_state <= NMI_PULSE;
          nmi_cnt   <= 8'(NMI_WIDTH);
          nNMI      <= 1'b0;
        end
        NMI_PULSE: begin
          nmi_cnt <= nmi_cnt - 8'd1;
          if (nmi_cnt == 8'd1) begin
            nmi_state <= NMI_HOLD;
            nNMI      <= 1'b1;
          end
        end
        NMI_HOLD: if (COIN) nmi_state <= NMI_IDLE;
        default: begin
          nmi_state <= NMI_IDLE;
          nNMI      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/blockade_bus_ctrl.md
# blockade_bus_ctrl

Sits directly downstream of the 8080-mode CPU wrapper and turns its address, data and active-low strobes into memory and I/O traffic. Decodes ROM, work RAM, video RAM and I/O ports, and drives the CPU read-data bus. Generates single-cycle write enables and latches output ports. Owns the CPU interrupt inputs: a VBLANK-driven `nINT` with acknowledge handling, and a coin-driven `nNMI` pulse.

## Interface
- `INT_VECTOR`, default 8'hFF: opcode returned on the interrupt-acknowledge cycle (RST 38h).
- `NMI_WIDTH`, default 16: `nNMI` low-pulse length in clocks, 1..255.
- `CLK` in 1: system clock; same clock as the CPU wrapper.
- `RESET` in 1: synchronous, active-high reset.
- `CPU_ADDR` in 16: CPU address.
- `CPU_DOUT` in 8: CPU write data.
- `CPU_DIN` out 8: read data to the CPU.
- `nMREQ`, `nIORQ`, `nRD`, `nWR` in 1 each: CPU strobes, active low.
- `nINT`, `nNMI` out 1 each: interrupt lines to the CPU.
- `ROM_ADDR` out 12, `ROM_DATA` in 8: program ROM at 0x0000–0x0FFF; synchronous read.
- `RAM_ADDR` out 8, `RAM_DATA` in 8, `RAM_WE` out 1: work RAM at 0xFF00–0xFFFF.
- `VRAM_ADDR` out 10, `VRAM_DATA` in 8, `VRAM_WE` out 1: video RAM at 0x8000–0x83FF.
- `WDATA` out 8: write data to RAM/VRAM, equal to `CPU_DOUT`.
- `IN1`, `IN2`, `IN4` in 8 each: input ports.
- `OUT1`, `OUT2`, `OUT4` out 8 each: latched output ports.
- `SND_STB` out 1: one-cycle pulse on a write to port 0x08.
- `VBLANK` in 1: video vertical blank, active high.
- `COIN` in 1: coin switch, active low, already synchronised.

## Operation
**Address passthrough**
- `ROM_ADDR`, `RAM_ADDR` and `VRAM_ADDR` are the low bits of `CPU_ADDR`, continuously.
- Memory data from the previous clock is therefore valid during the strobe cycle.

**Memory reads** (`nMREQ`=0, `nRD`=0)
- `CPU_DIN` selects ROM, VRAM or RAM by region.
- Unmapped addresses return 0xFF.

**I/O reads** (`nIORQ`=0, `nRD`=0)
- Port number is `CPU_ADDR[7:0]`.
- 0x01 returns `IN1`, 0x02 returns `IN2`, 0x04 returns `IN4`; any other port returns 0xFF.

**Interrupt acknowledge** (`nIORQ`=0, `nRD`=1, `nWR`=1)
- `CPU_DIN` = `INT_VECTOR`.
- Clears the interrupt-pending flag.

**CPU_DIN when idle**
- 0xFF whenever no read or acknowledge is active.

**Write detection**
- `wr_q` registers `nWR` each clock.
- A write event occurs when `nWR`=0 and `wr_q`=1, i.e. the first cycle of low.
- A strobe held low for several cycles produces exactly one event.

**Memory write event**
- Raises `RAM_WE` or `VRAM_WE` for that cycle only, per region.
- Writes to ROM or unmapped addresses are dropped.

**I/O write event**
- Port 0x01, 0x02 or 0x04: `CPU_DOUT` is latched into `OUT1`, `OUT2` or `OUT4` at the clock edge.
- Port 0x08: `SND_STB`=1 for one cycle.
- Any other port: no effect.

**Interrupt FSM** (flag `int_pend`)
- Set on a `VBLANK` rising edge, detected against registered `vb_q`.
- Cleared on the first cycle of an acknowledge.
- `nINT` = ~`int_pend`, registered.
- A rising edge in the same cycle as an acknowledge leaves `int_pend` set (set wins).

**NMI FSM** (states IDLE, PULSE, HOLD)
- IDLE → PULSE on a `COIN` falling edge; loads counter = `NMI_WIDTH`.
- PULSE: `nNMI`=0; counter decrements each clock; at 1 → HOLD.
- HOLD: waits until `COIN`=1, then → IDLE.
- Further coin edges during PULSE or HOLD are ignored.

## Timing
**Reset values**
- `nINT`=1, `nNMI`=1.
- `RAM_WE`=`VRAM_WE`=`SND_STB`=0.
- `OUT1`/`OUT2`/`OUT4`=0x00, `CPU_DIN`=0xFF.
- `int_pend`=0, NMI FSM in IDLE.
- `wr_q`=1, `vb_q`=1. Because `vb_q`=1, a `VBLANK` already high when reset releases does not interrupt.

**Latencies**
- `CPU_DIN`: combinational from strobes and address. Valid in the same cycle the strobe is low, which is the cycle the wrapper samples it.
- `RAM_WE`/`VRAM_WE`/`SND_STB`: combinational from the write event, exactly one clock wide. Address and `WDATA` are stable in that cycle.
- `OUT*`: update at the edge that ends the write-event cycle.
- `nINT`: low 1 clock after the `VBLANK` rising edge is seen; high 1 clock after the acknowledge cycle.
- `nNMI`: low 1 clock after the `COIN` edge; low for exactly `NMI_WIDTH` clocks.

**Reset mid-operation**
- `RESET` asserted during a strobe or an NMI pulse forces all reset values on the next edge.
- A pending interrupt is lost.

## Test plan
- Reset, then read 0x0005 with `ROM_DATA`=0x3E → `CPU_DIN`=0x3E in the strobe cycle. Read 0x5000 → 0xFF. `nINT`=`nNMI`=1.
- Hold `nWR` low for 3 cycles at 0x8123, `CPU_DOUT`=0xA5 → `VRAM_WE` high for exactly 1 cycle, `VRAM_ADDR`=0x123, `WDATA`=0xA5, `RAM_WE` stays 0.
- OUT to 0x02 with 0x5A → `OUT2`=0x5A next edge. OUT to 0x08 → `SND_STB` single pulse. OUT to 0x10 → no change anywhere.
- IN from 0x04 with `IN4`=0x7F → `CPU_DIN`=0x7F. IN from 0x03 → 0xFF.
- `VBLANK` rise → `nINT`=0 one clock later. Acknowledge cycle → `CPU_DIN`=0xFF, then `nINT`=1. Repeat with a `VBLANK` rise in the same cycle as the acknowledge → `nINT` stays 0.
- `COIN` falls → `nNMI` low for exactly 16 clocks. A second `COIN` toggle during the pulse is ignored. A new fall after `COIN` returns high → a new 16-clock pulse.
